bus_timer: RTL and testbench

//  Memory-mapped timer/counter that is the responder on the CPU data bus (busWe/busAddr/busWData/busRData).
//  It is selected by the top-level address decoder through busSel.
//  It provides a prescaled up-counter with auto-reload, a one-shot mode, a sticky overflow flag and a level irq.

---
 rtl/timer_pkg.sv | 35 +++
 rtl/tmr_prescaler.sv | 29 ++
 rtl/bus_timer.sv | 123 ++++++++++++
 tb/tb_bus_timer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared register map and bit positions for the bus_timer peripheral.
// Imported by the top level; the prescaler is self-contained.
package timer_pkg;

  localparam logic [2:0] REG_CTRL = 3'd0;
  localparam logic [2:0] REG_PSC  = 3'd1;
  localparam logic [2:0] REG_ARR  = 3'd2;
  localparam logic [2:0] REG_CNT  = 3'd3;
  localparam logic [2:0] REG_STAT = 3'd4;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_CLR     = 1;
  localparam int CTRL_IE      = 2;
  localparam int CTRL_ONESHOT = 3;

  localparam int STAT_OVF = 0;

  // CLR is a strobe, so it never appears in the read-back word.
  function automatic logic [31:0] pack_ctrl(input logic en, input logic ie, input logic oneshot);
    logic [31:0] w;
    w               = '0;
    w[CTRL_EN]      = en;
    w[CTRL_IE]      = ie;
    w[CTRL_ONESHOT] = oneshot;
    return w;
  endfunction

  function automatic logic [31:0] pack_stat(input logic ovf);
    logic [31:0] w;
    w           = '0;
    w[STAT_OVF] = ovf;
    return w;
  endfunction

endpackage

// File: rtl/tmr_prescaler.sv
// Prescaler for bus_timer: one tick every psc+1 enabled cycles.
// The count holds while disabled and is zeroed by a synchronous clear.
module tmr_prescaler #(
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [PSC_W-1:0] psc,
  output logic             tick
);

  logic [PSC_W-1:0] r_pcnt;

  // ">=" keeps a lowered psc from stranding the count above the new limit.
  assign tick = en && (r_pcnt >= psc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pcnt <= '0;
    end else if (clr || tick) begin
      r_pcnt <= '0;
    end else if (en) begin
      r_pcnt <= r_pcnt + PSC_W'(1);
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped prescaled up-counter with auto-reload, one-shot mode,
// sticky overflow flag and level interrupt; single-cycle bus responder.
module bus_timer
  import timer_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PSC_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        busSel,
  input  logic        busWe,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWData,
  output logic [31:0] busRData,
  output logic        irq
);

  logic             r_en;
  logic             r_ie;
  logic             r_oneshot;
  logic [PSC_W-1:0] r_psc;
  logic [CNT_W-1:0] r_arr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic       w_wr;
  logic [2:0] w_idx;
  logic       w_wr_ctrl;
  logic       w_wr_psc;
  logic       w_wr_arr;
  logic       w_wr_cnt;
  logic       w_wr_stat;
  logic       w_clr;
  logic       w_cnt_load;
  logic       w_tick;
  logic       w_reload;
  logic       w_ovf_set;
  logic       w_unused;

  assign w_wr      = busSel & busWe;
  assign w_idx     = busAddr[4:2];
  assign w_wr_ctrl = w_wr && (w_idx == REG_CTRL);
  assign w_wr_psc  = w_wr && (w_idx == REG_PSC);
  assign w_wr_arr  = w_wr && (w_idx == REG_ARR);
  assign w_wr_cnt  = w_wr && (w_idx == REG_CNT);
  assign w_wr_stat = w_wr && (w_idx == REG_STAT);

  assign w_clr      = w_wr_ctrl & busWData[CTRL_CLR];
  assign w_cnt_load = w_clr | w_wr_cnt;

  assign w_unused = &{1'b0, busAddr[31:5], busAddr[1:0], busWData};

  tmr_prescaler #(
    .PSC_W(PSC_W)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (r_en),
    .clr  (w_cnt_load),
    .psc  (r_psc),
    .tick (w_tick)
  );

  // A software load of CNT suppresses the tick entirely, including its overflow.
  assign w_reload  = w_tick && (r_cnt >= r_arr);
  assign w_ovf_set = w_reload & ~w_cnt_load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en      <= 1'b0;
      r_ie      <= 1'b0;
      r_oneshot <= 1'b0;
      r_psc     <= '0;
      r_arr     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_en      <= busWData[CTRL_EN];
        r_ie      <= busWData[CTRL_IE];
        r_oneshot <= busWData[CTRL_ONESHOT];
      end else if (w_ovf_set && r_oneshot) begin
        r_en <= 1'b0;
      end

      if (w_wr_psc) r_psc <= busWData[PSC_W-1:0];
      if (w_wr_arr) r_arr <= busWData[CNT_W-1:0];

      if (w_clr) begin
        r_cnt <= '0;
      end else if (w_wr_cnt) begin
        r_cnt <= busWData[CNT_W-1:0];
      end else if (w_tick) begin
        r_cnt <= w_reload ? '0 : r_cnt + CNT_W'(1);
      end

      // Hardware set outranks a same-cycle write-1-to-clear.
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_wr_stat && busWData[STAT_OVF]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign irq = r_ovf & r_ie;

  always_comb begin
    busRData = '0;
    if (busSel) begin
      case (w_idx)
        REG_CTRL: busRData = pack_ctrl(r_en, r_ie, r_oneshot);
        REG_PSC:  busRData = 32'(r_psc);
        REG_ARR:  busRData = 32'(r_arr);
        REG_CNT:  busRData = 32'(r_cnt);
        REG_STAT: busRData = pack_stat(r_ovf);
        default:  busRData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Directed self-checking bench for bus_timer: reset, prescaled counting,
// W1C races, one-shot, CNT load priority, async reset and read gating.
module tb_bus_timer;

  logic        clk;
  logic        reset;
  logic        busSel;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [31:0] busRData;
  logic        irq;

  int checks;
  int failures;

  bus_timer #(
    .CNT_W(32),
    .PSC_W(16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .busSel  (busSel),
    .busWe   (busWe),
    .busAddr (busAddr),
    .busWData(busWData),
    .busRData(busRData),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
      $display("check %-14s got=%h exp=%h", tag, got, exp);
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drives the write now; it commits at the next rising edge.
  task automatic wr(input int idx, input logic [31:0] data);
    busSel   = 1'b1;
    busWe    = 1'b1;
    busAddr  = 32'(idx) << 2;
    busWData = data;
    @(posedge clk);
    #1;
    busSel = 1'b0;
    busWe  = 1'b0;
    $display("write idx=%0d data=%h", idx, data);
  endtask

  task automatic rd(input int idx, output logic [31:0] data);
    busSel  = 1'b1;
    busWe   = 1'b0;
    busAddr = 32'(idx) << 2;
    #1;
    data   = busRData;
    busSel = 1'b0;
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string tag, input int idx, input logic [31:0] exp);
    logic [31:0] v;
    rd(idx, v);
    check(tag, v, exp);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    busSel   = 1'b0;
    busWe    = 1'b0;
    busAddr  = '0;
    busWData = '0;

    // 1. Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) rd_check($sformatf("rst_idx%0d", i), i, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);

    // 2. PSC=3, ARR=4, EN|IE: tick every 4 cycles, overflow at 20th
    wr(1, 32'd3);
    wr(2, 32'd4);
    rd_check("psc_rb", 1, 32'd3);
    wr(0, 32'h5);                       // edge P0
    rd_check("ctrl_rb", 0, 32'h5);
    tick_n(3);                          // P3
    rd_check("cnt_p3", 3, 32'd0);
    tick_n(1);                          // P4
    rd_check("cnt_p4", 3, 32'd1);
    tick_n(4);                          // P8
    rd_check("cnt_p8", 3, 32'd2);
    tick_n(8);                          // P16
    rd_check("cnt_p16", 3, 32'd4);
    tick_n(3);                          // P19
    rd_check("cnt_p19", 3, 32'd4);
    check("irq_p19", {31'b0, irq}, 32'h0);
    tick_n(1);                          // P20
    rd_check("cnt_p20", 3, 32'd0);
    rd_check("ovf_p20", 4, 32'h1);
    check("irq_p20", {31'b0, irq}, 32'h1);

    // 3. W1C, then W1C racing a hardware overflow
    wr(4, 32'h1);                       // P21
    rd_check("ovf_w1c", 4, 32'h0);
    check("irq_w1c", {31'b0, irq}, 32'h0);
    rd_check("cnt_p21", 3, 32'd0);
    tick_n(18);                         // P39
    rd_check("cnt_p39", 3, 32'd4);
    wr(4, 32'h1);                       // P40: overflow edge
    rd_check("ovf_race", 4, 32'h1);
    rd_check("cnt_p40", 3, 32'd0);
    check("irq_race", {31'b0, irq}, 32'h1);
    wr(0, 32'h0);
    wr(4, 32'h0);
    rd_check("ovf_w0", 4, 32'h1);
    wr(4, 32'h1);
    check("irq_off", {31'b0, irq}, 32'h0);

    // 4. One-shot: PSC=0, ARR=2
    wr(1, 32'd0);
    wr(2, 32'd2);
    wr(0, 32'h9);                       // Q0
    rd_check("os_q0", 3, 32'd0);
    tick_n(1);
    rd_check("os_q1", 3, 32'd1);
    tick_n(1);
    rd_check("os_q2", 3, 32'd2);
    tick_n(1);
    rd_check("os_q3", 3, 32'd0);
    rd_check("os_ctrl", 0, 32'h8);
    rd_check("os_ovf", 4, 32'h1);
    check("os_irq", {31'b0, irq}, 32'h0);
    tick_n(2);
    rd_check("os_hold", 3, 32'd0);
    wr(4, 32'h1);
    // EN write on the auto-clear edge wins
    wr(0, 32'h9);                       // R0
    tick_n(2);                          // R2
    rd_check("os2_r2", 3, 32'd2);
    wr(0, 32'h9);                       // R3: overflow edge
    rd_check("os2_ctrl", 0, 32'h9);
    rd_check("os2_cnt", 3, 32'd0);
    rd_check("os2_ovf", 4, 32'h1);
    tick_n(1);
    rd_check("os2_r4", 3, 32'd1);
    wr(0, 32'h0);
    wr(4, 32'h1);

    // 5. CNT load above ARR, and CNT write on a tick edge
    wr(1, 32'd1);
    wr(2, 32'd5);
    wr(3, 32'd0);
    wr(0, 32'h1);                       // S0
    tick_n(4);                          // S4
    rd_check("ld_s4", 3, 32'd2);
    wr(3, 32'h10);                      // S5
    rd_check("ld_s5", 3, 32'h10);
    tick_n(1);
    rd_check("ld_s6", 3, 32'h10);
    rd_check("ld_s6_ovf", 4, 32'h0);
    tick_n(1);                          // S7: tick reloads
    rd_check("ld_s7", 3, 32'd0);
    rd_check("ld_s7_ovf", 4, 32'h1);
    wr(4, 32'h1);                       // S8
    wr(3, 32'd3);                       // S9: tick edge
    rd_check("ld_win", 3, 32'd3);
    rd_check("ld_win_ovf", 4, 32'h0);
    tick_n(2);                          // S11
    rd_check("ld_s11", 3, 32'd4);

    // 6. Async reset mid-count, read gating, unused index
    wr(3, 32'd3);
    #3;
    reset = 1'b0;
    #1;
    rd_check("ar_cnt", 3, 32'd0);
    rd_check("ar_ctrl", 0, 32'h0);
    rd_check("ar_psc", 1, 32'h0);
    rd_check("ar_arr", 2, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick_n(3);
    rd_check("ar_hold", 3, 32'd0);
    wr(2, 32'd7);
    rd_check("arr7", 2, 32'd7);
    busSel  = 1'b0;
    busWe   = 1'b0;
    busAddr = 32'd2 << 2;
    #1;
    check("nosel_rd", busRData, 32'h0);
    wr(5, 32'hFFFF_FFFF);
    rd_check("idx5", 5, 32'h0);
    rd_check("arr_keep", 2, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
